// File: rtl/ex_mc_pkg.sv
`default_nettype none
// ============================================================================
// ex_mc_pkg : op/sel codes, divider state encoding and handshake constants
// Revision  : 1.0 - initial release
// ============================================================================
package ex_mc_pkg;

  // Result classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // Operation codes
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mc_div_iter.sv
`default_nettype none
// ============================================================================
// div_iter : iterative restoring signed/unsigned divider, one bit per cycle
// Revision : 1.0 - initial release
// ============================================================================
module div_iter import ex_mc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;

  logic [DATA_W-1:0] w_mag_a, w_mag_b, w_quot_next, w_rem_next;
  logic [DATA_W:0]   w_rem_shift, w_diff;

  assign w_mag_a = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
  assign w_mag_b = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;

  // quot_q starts as the dividend and shifts quotient bits in from the right
  assign w_rem_shift = {rem_q, quot_q[DATA_W-1]};
  assign w_diff      = w_rem_shift - {1'b0, dvsr_q};
  assign w_quot_next = {quot_q[DATA_W-2:0], ~w_diff[DATA_W]};
  assign w_rem_next  = w_diff[DATA_W] ? w_rem_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (abort_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i == DIV_START) begin
            if (b_i == '0) begin
              quot_d     = '1;
              rem_d      = a_i;
              neg_quot_d = 1'b0;
              neg_rem_d  = 1'b0;
              state_d    = DIV_DONE;
            end else begin
              quot_d     = w_mag_a;
              rem_d      = '0;
              dvsr_d     = w_mag_b;
              neg_quot_d = signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              neg_rem_d  = signed_i & a_i[DATA_W-1];
              cnt_d      = '0;
              state_d    = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          quot_d = w_quot_next;
          rem_d  = w_rem_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            // Signs are applied on the last step so the outputs come straight from flops
            quot_d  = neg_quot_q ? -w_quot_next : w_quot_next;
            rem_d   = neg_rem_q ? -w_rem_next : w_rem_next;
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign busy_o = (state_q == DIV_BUSY);
  assign done_o = (state_q == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/ex_mc.sv
`default_nettype none
// ============================================================================
// ex_mc    : execute stage with single-cycle ALU/multiply and iterative divide
// Revision : 1.0 - initial release
// ============================================================================
module ex_mc import ex_mc_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_a_i,
  input  logic [DATA_W-1:0]     data_b_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
  input  logic [2:0]            sel_i,
  input  logic [7:0]            op_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] w_reg_addr_o,
  output logic [DATA_W-1:0]     w_data_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_W-1:0]     w_logic_res, w_shift_res, w_arith_res, w_result;
  logic                  w_div_op, w_div_start, w_mult_op, w_mult_signed;
  logic                  w_dv_busy, w_dv_done;
  logic [DATA_W-1:0]     w_dv_quot, w_dv_rem;
  logic [2*DATA_W-1:0]   w_a_ext, w_b_ext, w_prod;

  assign w_shamt = data_a_i[SHAMT_W-1:0];

  always_comb begin
    w_logic_res = '0;
    case (op_i)
      EXE_OR_OP:  w_logic_res = data_a_i | data_b_i;
      EXE_AND_OP: w_logic_res = data_a_i & data_b_i;
      EXE_XOR_OP: w_logic_res = data_a_i ^ data_b_i;
      EXE_NOR_OP: w_logic_res = ~(data_a_i | data_b_i);
      default:    w_logic_res = '0;
    endcase
  end

  always_comb begin
    w_shift_res = '0;
    case (op_i)
      EXE_SLL_OP: w_shift_res = data_b_i << w_shamt;
      EXE_SRL_OP: w_shift_res = data_b_i >> w_shamt;
      EXE_SRA_OP: w_shift_res = $unsigned($signed(data_b_i) >>> w_shamt);
      default:    w_shift_res = '0;
    endcase
  end

  always_comb begin
    w_arith_res = '0;
    case (op_i)
      EXE_ADDU_OP: w_arith_res = data_a_i + data_b_i;
      EXE_SUBU_OP: w_arith_res = data_a_i - data_b_i;
      EXE_SLT_OP:  w_arith_res = {{(DATA_W-1){1'b0}}, ($signed(data_a_i) < $signed(data_b_i))};
      EXE_SLTU_OP: w_arith_res = {{(DATA_W-1){1'b0}}, (data_a_i < data_b_i)};
      default:     w_arith_res = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (sel_i)
      EXE_RES_LOGIC:            w_result = w_logic_res;
      EXE_RES_SHIFT:            w_result = w_shift_res;
      EXE_RES_ARITH:            w_result = w_arith_res;
      EXE_RES_NOP, EXE_RES_MOVE: w_result = '0;
      default:                  w_result = '0;
    endcase
  end

  // Operands are extended to full product width so one multiplier serves both signednesses
  assign w_mult_op     = (op_i == EXE_MULT_OP) || (op_i == EXE_MULTU_OP);
  assign w_mult_signed = (op_i == EXE_MULT_OP);
  assign w_a_ext = w_mult_signed ? {{DATA_W{data_a_i[DATA_W-1]}}, data_a_i}
                                 : {{DATA_W{1'b0}}, data_a_i};
  assign w_b_ext = w_mult_signed ? {{DATA_W{data_b_i[DATA_W-1]}}, data_b_i}
                                 : {{DATA_W{1'b0}}, data_b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_div_op    = is_div_op(op_i);
  assign w_div_start = (w_div_op && !w_dv_busy && !w_dv_done) ? DIV_START : DIV_STOP;

  div_iter #(
    .DATA_W (DATA_W)
  ) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_div_start),
    .signed_i (op_i == EXE_DIV_OP),
    .a_i      (data_a_i),
    .b_i      (data_b_i),
    .abort_i  (flush_i),
    .busy_o   (w_dv_busy),
    .done_o   (w_dv_done),
    .quot_o   (w_dv_quot),
    .rem_o    (w_dv_rem)
  );

  always_comb begin
    stall_o      = 1'b0;
    we_o         = 1'b0;
    w_reg_addr_o = '0;
    w_data_o     = '0;
    whilo_o      = 1'b0;
    hi_o         = '0;
    lo_o         = '0;
    if (!rst) begin
      we_o         = we_i;
      w_reg_addr_o = w_reg_addr_i;
      w_data_o     = w_result;
      stall_o      = !flush_i && (w_div_start || w_dv_busy);
      if (w_dv_done && !flush_i) begin
        whilo_o = 1'b1;
        hi_o    = w_dv_rem;
        lo_o    = w_dv_quot;
      end else if (w_mult_op) begin
        whilo_o = 1'b1;
        hi_o    = w_prod[2*DATA_W-1:DATA_W];
        lo_o    = w_prod[DATA_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mc.sv
`default_nettype none
// ============================================================================
// tb_ex_mc : vector table, reference-model random tests and divide sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mc;
  import ex_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a_i, data_b_i;
  logic        we_i;
  logic [4:0]  w_reg_addr_i;
  logic [2:0]  sel_i;
  logic [7:0]  op_i;
  logic        flush_i;
  logic        stall_o, we_o, whilo_o;
  logic [4:0]  w_reg_addr_o;
  logic [31:0] w_data_o, hi_o, lo_o;

  int n_chk  = 0;
  int n_pass = 0;

  ex_mc #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_a_i     (data_a_i),
    .data_b_i     (data_b_i),
    .we_i         (we_i),
    .w_reg_addr_i (w_reg_addr_i),
    .sel_i        (sel_i),
    .op_i         (op_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .we_o         (we_o),
    .w_reg_addr_o (w_reg_addr_o),
    .w_data_o     (w_data_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] a, b, w;
    logic        whilo;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    sel_i = s; op_i = o; data_a_i = a; data_b_i = b;
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] s, input logic [7:0] o,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                              input logic wl, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = nm; v.sel = s; v.op = o; v.a = a; v.b = b; v.w = w;
    v.whilo = wl; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  // Reference: result written to the GPR, from the arithmetic meaning of each op
  function automatic logic [31:0] ref_w(input logic [2:0] s, input logic [7:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    int     sh = int'(a % 32);
    if (s == EXE_RES_LOGIC) begin
      if (o == EXE_OR_OP)  return a | b;
      if (o == EXE_AND_OP) return a & b;
      if (o == EXE_XOR_OP) return a ^ b;
      if (o == EXE_NOR_OP) return ~(a | b);
    end else if (s == EXE_RES_SHIFT) begin
      if (o == EXE_SLL_OP) return 32'(longint'(b) * (64'd1 << sh));
      if (o == EXE_SRL_OP) return 32'(longint'(b) / (64'd1 << sh));
      if (o == EXE_SRA_OP) return 32'(sb >>> sh);
    end else if (s == EXE_RES_ARITH) begin
      if (o == EXE_ADDU_OP) return 32'(longint'(a) + longint'(b));
      if (o == EXE_SUBU_OP) return 32'(longint'(a) - longint'(b));
      if (o == EXE_SLT_OP)  return (sa < sb) ? 32'd1 : 32'd0;
      if (o == EXE_SLTU_OP) return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
    end
    return 32'd0;
  endfunction

  function automatic logic [63:0] ref_mult(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    if (is_signed) return 64'(sa * sb);
    return ua * ub;
  endfunction

  // Returns {hi=remainder, lo=quotient}
  function automatic logic [63:0] ref_div(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (is_signed) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic run_div(input string nm, input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_hl = ref_div(o == EXE_DIV_OP, a, b);
    int          exp_n  = (b == 32'd0) ? 1 : 33;
    int          n      = 0;
    @(negedge clk);
    drive(EXE_RES_NOP, o, a, b);
    #1;
    while (stall_o === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("%s stall cycles", nm), 64'(n), 64'(exp_n));
    chk($sformatf("%s whilo", nm), {63'd0, whilo_o}, 64'd1);
    chk($sformatf("%s lo", nm), {32'd0, lo_o}, {32'd0, exp_hl[31:0]});
    chk($sformatf("%s hi", nm), {32'd0, hi_o}, {32'd0, exp_hl[63:32]});
    @(negedge clk);
    drive(EXE_RES_NOP, 8'd0, 32'd0, 32'd0);
    #1;
    chk($sformatf("%s whilo after", nm), {63'd0, whilo_o}, 64'd0);
  endtask

  vec_t vt[17];
  logic [7:0] ops[13];

  initial begin
    vt[0]  = mk("or",     EXE_RES_LOGIC, EXE_OR_OP,   32'h0000F0F0, 32'h00FF00FF, 32'h00FFF0FF, 0, 0, 0);
    vt[1]  = mk("and",    EXE_RES_LOGIC, EXE_AND_OP,  32'h0000F0F0, 32'h00FF00FF, 32'h000000F0, 0, 0, 0);
    vt[2]  = mk("xor",    EXE_RES_LOGIC, EXE_XOR_OP,  32'h0000F0F0, 32'h00FF00FF, 32'h00FFF00F, 0, 0, 0);
    vt[3]  = mk("nor",    EXE_RES_LOGIC, EXE_NOR_OP,  32'h0000F0F0, 32'h00FF00FF, 32'hFF000F00, 0, 0, 0);
    vt[4]  = mk("slt",    EXE_RES_ARITH, EXE_SLT_OP,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0);
    vt[5]  = mk("sltu",   EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 0, 0);
    vt[6]  = mk("sra",    EXE_RES_SHIFT, EXE_SRA_OP,  32'h4,        32'h80000000, 32'hF8000000, 0, 0, 0);
    vt[7]  = mk("srl",    EXE_RES_SHIFT, EXE_SRL_OP,  32'h4,        32'h80000000, 32'h08000000, 0, 0, 0);
    vt[8]  = mk("sll",    EXE_RES_SHIFT, EXE_SLL_OP,  32'h24,       32'h1,        32'h10,       0, 0, 0);
    vt[9]  = mk("addu",   EXE_RES_ARITH, EXE_ADDU_OP, 32'hFFFFFFFF, 32'h2,        32'h1,        0, 0, 0);
    vt[10] = mk("subu",   EXE_RES_ARITH, EXE_SUBU_OP, 32'h0,        32'h1,        32'hFFFFFFFF, 0, 0, 0);
    vt[11] = mk("badop",  EXE_RES_LOGIC, EXE_SLL_OP,  32'h1,        32'h2,        32'h0,        0, 0, 0);
    vt[12] = mk("movesel",EXE_RES_MOVE,  EXE_OR_OP,   32'h1,        32'h2,        32'h0,        0, 0, 0);
    vt[13] = mk("mult",   EXE_RES_NOP,   EXE_MULT_OP, 32'hFFFFFFFE, 32'h3,        32'h0,        1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    vt[14] = mk("multu",  EXE_RES_NOP,   EXE_MULTU_OP,32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1, 32'hFFFFFFFE, 32'h00000001);
    vt[15] = mk("slt2",   EXE_RES_ARITH, EXE_SLT_OP,  32'h1,        32'hFFFFFFFF, 32'h0,        0, 0, 0);
    vt[16] = mk("sltu2",  EXE_RES_ARITH, EXE_SLTU_OP, 32'h1,        32'hFFFFFFFF, 32'h1,        0, 0, 0);
    ops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
            EXE_SLT_OP, EXE_SLTU_OP, EXE_ADDU_OP, EXE_SUBU_OP, EXE_MULT_OP, EXE_MULTU_OP};

    // Reset state with live-looking inputs
    rst = 1'b1; flush_i = 1'b0; we_i = 1'b1; w_reg_addr_i = 5'd7;
    drive(EXE_RES_LOGIC, EXE_OR_OP, 32'h1234, 32'h5678);
    #12;
    chk("rst w_data", {32'd0, w_data_o}, 64'd0);
    chk("rst we", {63'd0, we_o}, 64'd0);
    chk("rst addr", {59'd0, w_reg_addr_o}, 64'd0);
    chk("rst stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].sel, vt[i].op, vt[i].a, vt[i].b);
      #1;
      chk({vt[i].name, " w_data"}, {32'd0, w_data_o}, {32'd0, vt[i].w});
      chk({vt[i].name, " whilo"}, {63'd0, whilo_o}, {63'd0, vt[i].whilo});
      chk({vt[i].name, " hi"}, {32'd0, hi_o}, {32'd0, vt[i].hi});
      chk({vt[i].name, " lo"}, {32'd0, lo_o}, {32'd0, vt[i].lo});
      chk({vt[i].name, " stall"}, {63'd0, stall_o}, 64'd0);
    end

    // Random single-cycle ops against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  s = 3'($urandom_range(0, 7));
      logic [7:0]  o = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 12)];
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      logic        mo;
      logic [63:0] p;
      if (is_div_op(o)) o = EXE_OR_OP;
      mo = (o == EXE_MULT_OP) || (o == EXE_MULTU_OP);
      p  = mo ? ref_mult(o == EXE_MULT_OP, a, b) : 64'd0;
      @(negedge clk);
      drive(s, o, a, b);
      we_i = 1'($urandom); w_reg_addr_i = 5'($urandom);
      #1;
      chk($sformatf("rnd%0d w_data", i), {32'd0, w_data_o}, {32'd0, ref_w(s, o, a, b)});
      chk($sformatf("rnd%0d whilo", i), {63'd0, whilo_o}, {63'd0, mo});
      chk($sformatf("rnd%0d hilo", i), {hi_o, lo_o}, p);
      chk($sformatf("rnd%0d stall", i), {63'd0, stall_o}, 64'd0);
      chk($sformatf("rnd%0d wb", i), {58'd0, we_o, w_reg_addr_o}, {58'd0, we_i, w_reg_addr_i});
    end

    run_div("div -7/2",   EXE_DIV_OP,  32'hFFFFFFF9, 32'd2);
    run_div("divu -7/2",  EXE_DIVU_OP, 32'hFFFFFFF9, 32'd2);
    run_div("divu 5/0",   EXE_DIVU_OP, 32'd5,        32'd0);
    run_div("div -9/0",   EXE_DIV_OP,  32'hFFFFFFF7, 32'd0);
    run_div("div min/-1", EXE_DIV_OP,  32'h80000000, 32'hFFFFFFFF);
    run_div("div 7/-2",   EXE_DIV_OP,  32'd7,        32'hFFFFFFFE);

    // Flush at BUSY cycle 10
    @(negedge clk);
    drive(EXE_RES_NOP, EXE_DIV_OP, 32'd100, 32'd7);
    #1;
    chk("flush start stall", {63'd0, stall_o}, 64'd1);
    for (int i = 1; i <= 10; i++) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush stall", {63'd0, stall_o}, 64'd0);
    chk("flush whilo", {63'd0, whilo_o}, 64'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      flush_i = 1'b0;
      drive(EXE_RES_NOP, 8'd0, 32'd0, 32'd0);
      #1;
      chk($sformatf("post-flush %0d", i), {62'd0, stall_o, whilo_o}, 64'd0);
    end
    run_div("div after flush", EXE_DIV_OP, 32'hFFFFFF9C, 32'd7);

    // Asynchronous reset mid-divide
    @(negedge clk);
    we_i = 1'b1; w_reg_addr_i = 5'd9;
    drive(EXE_RES_LOGIC, EXE_DIV_OP, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst stall", {63'd0, stall_o}, 64'd0);
    chk("arst outs", {26'd0, we_o, w_reg_addr_o, whilo_o, w_data_o}, 64'd0);
    chk("arst hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(EXE_RES_LOGIC, EXE_OR_OP, 32'h0F, 32'hF0);
    #1;
    chk("after arst stall", {63'd0, stall_o}, 64'd0);
    chk("after arst w_data", {32'd0, w_data_o}, 64'h0FF);
    @(negedge clk);
    #1;
    chk("after arst whilo", {63'd0, whilo_o}, 64'd0);

    // Random divides
    for (int i = 0; i < 25; i++) begin
      logic [7:0]  o = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      logic [31:0] a = $urandom;
      logic [31:0] b;
      int r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r <= 3) b = 32'($urandom_range(1, 15));
      else if (r == 4) b = 32'hFFFFFFFF;
      else b = $urandom;
      run_div($sformatf("rdiv%0d", i), o, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
